trng_health_packer: RTL and testbench

TRNG_HEALTH_PACKER -- requirements
Module: trng_health_packer

---
 rtl/trng_pkg.sv | 13 +
 rtl/trng_health_packer_if.sv | 17 +
 rtl/trng_word_fifo.sv | 51 +++++
 rtl/trng_health_packer.sv | 152 +++++++++++++++
 tb/tb_trng_health_packer.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/trng_pkg.sv
// Shared defaults and mode encoding for the TRNG health-test word packer.
package trng_pkg;

  localparam int DEF_WORD_W     = 8;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_RCT_CUTOFF = 32;
  localparam int DEF_APT_WINDOW = 512;
  localparam int DEF_APT_CUTOFF = 410;

  localparam logic MODE_GATED = 1'b0;
  localparam logic MODE_RAW   = 1'b1;

endpackage

// File: rtl/trng_health_packer_if.sv
// Word stream bundle between the packer FIFO and its consumer.
interface trng_health_packer_if
  import trng_pkg::*;
#(
  parameter int WORD_W = DEF_WORD_W
) ();

  // A word transfers on a cycle where word_valid and word_ready are both high;
  // while word_valid is high and word_ready low, word_data holds steady.
  logic [WORD_W-1:0] word_data;
  logic              word_valid;
  logic              word_ready;

  modport master (output word_data, output word_valid, input word_ready);
  modport slave  (input word_data, input word_valid, output word_ready);

endinterface

// File: rtl/trng_word_fifo.sv
// Word FIFO with wrap-bit pointers; a push into a full FIFO is dropped unless a pop frees a slot.
module trng_word_fifo
  import trng_pkg::*;
#(
  parameter int WORD_W     = DEF_WORD_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push,
  input  logic [WORD_W-1:0]    push_data,
  output logic                 overflow,
  trng_health_packer_if.master pop_side
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [WORD_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              empty;
  logic              full;
  logic              pop;
  logic              push_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop     = !empty && pop_side.word_ready;
  assign push_ok = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !push_ok) overflow <= 1'b1;
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign pop_side.word_valid = !empty;
  assign pop_side.word_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/trng_health_packer.sv
// Runs repetition-count and adaptive-proportion health tests on a raw entropy bit stream
// and packs accepted bits LSB-first into words queued for a valid/ready consumer.
module trng_health_packer
  import trng_pkg::*;
#(
  parameter int WORD_W     = DEF_WORD_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int RCT_CUTOFF = DEF_RCT_CUTOFF,
  parameter int APT_WINDOW = DEF_APT_WINDOW,
  parameter int APT_CUTOFF = DEF_APT_CUTOFF
) (
  input  logic              TRNG_Clock,
  input  logic              TRNG_Reset,
  input  logic              sample_bit,
  input  logic              sample_valid,
  input  logic              ctrl_mode,
  input  logic              clear_fail,
  output logic [WORD_W-1:0] word_data,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              failure,
  output logic              overflow
);

  localparam int RCT_W  = $clog2(RCT_CUTOFF) + 1;
  localparam int APT_IW = $clog2(APT_WINDOW) + 1;
  localparam int APT_CW = $clog2(APT_CUTOFF) + 1;
  localparam int BIT_W  = $clog2(WORD_W) + 1;

  // Repetition count test
  logic             rct_seen;
  logic             rct_last;
  logic [RCT_W-1:0] rct_cnt;
  logic [RCT_W-1:0] rct_next;
  logic             rct_evt;

  always_comb begin
    rct_next = rct_cnt;
    if (!rct_seen || (sample_bit != rct_last)) rct_next = RCT_W'(1);
    else if (rct_cnt != RCT_W'(RCT_CUTOFF)) rct_next = rct_cnt + 1'b1;
  end

  // A run held at the cutoff keeps flagging, so a clear during a stuck source re-fails.
  assign rct_evt = sample_valid && (rct_next == RCT_W'(RCT_CUTOFF));

  always_ff @(posedge TRNG_Clock) begin
    if (TRNG_Reset) begin
      rct_seen <= 1'b0;
      rct_last <= 1'b0;
      rct_cnt  <= '0;
    end else if (sample_valid) begin
      rct_seen <= 1'b1;
      rct_last <= sample_bit;
      rct_cnt  <= rct_next;
    end
  end

  // Adaptive proportion test; apt_idx == 0 means the next sample opens a window
  logic              apt_ref;
  logic [APT_IW-1:0] apt_idx;
  logic [APT_IW-1:0] apt_idx_next;
  logic [APT_CW-1:0] apt_cnt;
  logic [APT_CW-1:0] apt_cnt_next;
  logic              apt_evt;

  always_comb begin
    apt_cnt_next = apt_cnt;
    if (apt_idx == '0) apt_cnt_next = APT_CW'(1);
    else if ((sample_bit == apt_ref) && (apt_cnt != APT_CW'(APT_CUTOFF)))
      apt_cnt_next = apt_cnt + 1'b1;
    apt_idx_next = (apt_idx == APT_IW'(APT_WINDOW - 1)) ? '0 : apt_idx + 1'b1;
  end

  assign apt_evt = sample_valid && (apt_cnt_next == APT_CW'(APT_CUTOFF)) &&
                   ((apt_idx == '0) || (apt_cnt != APT_CW'(APT_CUTOFF)));

  always_ff @(posedge TRNG_Clock) begin
    if (TRNG_Reset) begin
      apt_ref <= 1'b0;
      apt_idx <= '0;
      apt_cnt <= '0;
    end else if (sample_valid) begin
      if (apt_idx == '0) apt_ref <= sample_bit;
      apt_idx <= apt_idx_next;
      apt_cnt <= apt_cnt_next;
    end
  end

  logic fail_evt;
  assign fail_evt = rct_evt || apt_evt;

  always_ff @(posedge TRNG_Clock) begin
    if (TRNG_Reset) failure <= 1'b0;
    else if (fail_evt) failure <= 1'b1;
    else if (clear_fail) failure <= 1'b0;
  end

  // Packer: a mode change restarts the word, and the same-cycle sample becomes its bit 0
  logic              mode_q;
  logic              mode_chg;
  logic              pack_en;
  logic              push;
  logic [BIT_W-1:0]  bit_cnt;
  logic [BIT_W-1:0]  start_idx;
  logic [WORD_W-1:0] shift_q;
  logic [WORD_W-1:0] packed_word;

  assign mode_chg    = (ctrl_mode != mode_q);
  assign pack_en     = sample_valid && ((ctrl_mode == MODE_RAW) || (!failure && !fail_evt));
  assign start_idx   = mode_chg ? '0 : bit_cnt;
  assign packed_word = (mode_chg ? '0 : shift_q) | (WORD_W'(sample_bit) << start_idx);
  assign push        = pack_en && (start_idx == BIT_W'(WORD_W - 1));

  always_ff @(posedge TRNG_Clock) begin
    if (TRNG_Reset) begin
      mode_q  <= MODE_GATED;
      shift_q <= '0;
      bit_cnt <= '0;
    end else begin
      mode_q <= ctrl_mode;
      if (push) begin
        shift_q <= '0;
        bit_cnt <= '0;
      end else if (pack_en) begin
        shift_q <= packed_word;
        bit_cnt <= start_idx + 1'b1;
      end else if (mode_chg || ((ctrl_mode == MODE_GATED) && fail_evt)) begin
        shift_q <= '0;
        bit_cnt <= '0;
      end
    end
  end

  trng_health_packer_if #(.WORD_W(WORD_W)) word_bus ();

  trng_word_fifo #(
    .WORD_W     (WORD_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (TRNG_Clock),
    .rst       (TRNG_Reset),
    .push      (push),
    .push_data (packed_word),
    .overflow  (overflow),
    .pop_side  (word_bus)
  );

  assign word_data           = word_bus.word_data;
  assign word_valid          = word_bus.word_valid;
  assign word_bus.word_ready = word_ready;

endmodule

// File: tb/tb_trng_health_packer.sv
// Directed bench: table of single-cycle vectors plus hand-written multi-cycle sequences.
module tb_trng_health_packer;
  import trng_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, sample_bit, sample_valid, ctrl_mode, clear_fail, failure, overflow;
  trng_health_packer_if #(.WORD_W(8)) cons ();

  trng_health_packer #(
    .WORD_W(8), .FIFO_DEPTH(4), .RCT_CUTOFF(4), .APT_WINDOW(512), .APT_CUTOFF(410)
  ) dut (
    .TRNG_Clock   (clk),
    .TRNG_Reset   (rst),
    .sample_bit   (sample_bit),
    .sample_valid (sample_valid),
    .ctrl_mode    (ctrl_mode),
    .clear_fail   (clear_fail),
    .word_data    (cons.word_data),
    .word_valid   (cons.word_valid),
    .word_ready   (cons.word_ready),
    .failure      (failure),
    .overflow     (overflow)
  );

  logic       b_bit, b_valid, b_failure, b_overflow, b_word_valid;
  logic [7:0] b_word_data;

  trng_health_packer #(
    .WORD_W(8), .FIFO_DEPTH(4), .RCT_CUTOFF(32), .APT_WINDOW(16), .APT_CUTOFF(12)
  ) dut_apt (
    .TRNG_Clock   (clk),
    .TRNG_Reset   (rst),
    .sample_bit   (b_bit),
    .sample_valid (b_valid),
    .ctrl_mode    (MODE_GATED),
    .clear_fail   (1'b0),
    .word_data    (b_word_data),
    .word_valid   (b_word_valid),
    .word_ready   (1'b1),
    .failure      (b_failure),
    .overflow     (b_overflow)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic       b;
    logic       v;
    logic       clr;
    logic       ev;
    logic [7:0] ed;
    logic       ef;
  } vec_t;
  vec_t vecs[$];

  function automatic void add(input logic b, input logic v, input logic clr,
                              input logic ev, input logic [7:0] ed, input logic ef);
    vec_t t;
    t.b = b; t.v = v; t.clr = clr; t.ev = ev; t.ed = ed; t.ef = ef;
    vecs.push_back(t);
  endfunction

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    sample_bit   = b;
    sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w);
    for (int i = 0; i < 8; i++) send_bit(w[i]);
  endtask

  task automatic b_send(input logic b);
    b_bit   = b;
    b_valid = 1'b1;
    tick();
    b_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] fw [5];
    logic       apt_w1 [16];
    logic       apt_w2 [14];
    int         n;

    rst = 1'b1; sample_bit = 1'b0; sample_valid = 1'b0; ctrl_mode = MODE_GATED;
    clear_fail = 1'b0; cons.word_ready = 1'b1; b_bit = 1'b0; b_valid = 1'b0;
    tick(); tick();
    check1("reset_word_valid", cons.word_valid, 1'b0);
    check8("reset_word_data", cons.word_data, 8'h00);
    check1("reset_failure", failure, 1'b0);
    check1("reset_overflow", overflow, 1'b0);
    check1("reset_apt_failure", b_failure, 1'b0);
    rst = 1'b0;

    // Basic packing 1,0,1,1,0,0,1,0 -> 0x4D, then popped
    add(1, 1, 0, 0, 8'h00, 0); add(0, 1, 0, 0, 8'h00, 0);
    add(1, 1, 0, 0, 8'h00, 0); add(1, 1, 0, 0, 8'h00, 0);
    add(0, 1, 0, 0, 8'h00, 0); add(0, 1, 0, 0, 8'h00, 0);
    add(1, 1, 0, 0, 8'h00, 0); add(0, 1, 0, 1, 8'h4D, 0);
    add(0, 0, 0, 0, 8'h00, 0);
    // RCT cutoff 4: three packed bits, then five 1s; fail on the 4th
    add(0, 1, 0, 0, 8'h00, 0); add(1, 1, 0, 0, 8'h00, 0);
    add(0, 1, 0, 0, 8'h00, 0); add(1, 1, 0, 0, 8'h00, 0);
    add(1, 1, 0, 0, 8'h00, 0); add(1, 1, 0, 0, 8'h00, 0);
    add(1, 1, 0, 0, 8'h00, 1); add(1, 1, 0, 0, 8'h00, 1);
    add(0, 0, 1, 0, 8'h00, 0);
    // After clear: 0,1,1,0,1,0,0,1 -> 0x96
    add(0, 1, 0, 0, 8'h00, 0); add(1, 1, 0, 0, 8'h00, 0);
    add(1, 1, 0, 0, 8'h00, 0); add(0, 1, 0, 0, 8'h00, 0);
    add(1, 1, 0, 0, 8'h00, 0); add(0, 1, 0, 0, 8'h00, 0);
    add(0, 1, 0, 0, 8'h00, 0); add(1, 1, 0, 1, 8'h96, 0);
    add(0, 0, 0, 0, 8'h00, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      sample_bit   = vecs[i].b;
      sample_valid = vecs[i].v;
      clear_fail   = vecs[i].clr;
      tick();
      check1($sformatf("vec%0d_word_valid", i), cons.word_valid, vecs[i].ev);
      check8($sformatf("vec%0d_word_data", i), cons.word_data, vecs[i].ed);
      check1($sformatf("vec%0d_failure", i), failure, vecs[i].ef);
    end
    sample_valid = 1'b0;
    clear_fail   = 1'b0;

    // Overflow: five words with the consumer stalled
    fw = '{8'h55, 8'hAA, 8'h33, 8'h69, 8'hCC};
    cons.word_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send_word(fw[i]);
      if (i < 4) exp_q.push_back(fw[i]);
      if (i == 3) begin
        check1("fifo_full_no_overflow", overflow, 1'b0);
        check1("fifo_full_valid", cons.word_valid, 1'b1);
      end
    end
    check1("fifo_overflow_set", overflow, 1'b1);
    check8("fifo_head_after_overflow", cons.word_data, 8'h55);
    tick();
    check8("fifo_head_stable", cons.word_data, 8'h55);
    cons.word_ready = 1'b1;
    n = 0;
    while (cons.word_valid && n < 8) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL fifo_extra_word: got 0x%02h expected none", cons.word_data);
      end else begin
        check8("fifo_pop_data", cons.word_data, exp_q.pop_front());
      end
      tick();
      n++;
    end
    check8("fifo_pop_count", 8'(n), 8'd4);
    check1("fifo_drained_valid", cons.word_valid, 1'b0);
    check1("fifo_overflow_sticky", overflow, 1'b1);

    // Failure set in mode 0, then event together with clear keeps it set
    send_bit(1'b1);
    send_bit(1'b1);
    check1("rct_fail_mode0", failure, 1'b1);
    send_bit(1'b1);
    clear_fail = 1'b1;
    send_bit(1'b1);
    clear_fail = 1'b0;
    check1("fail_event_beats_clear", failure, 1'b1);

    // Raw mode still packs while failed
    ctrl_mode = MODE_RAW;
    tick();
    send_word(8'hF0);
    check1("raw_word_valid", cons.word_valid, 1'b1);
    check8("raw_word_data", cons.word_data, 8'hF0);
    check1("raw_failure_held", failure, 1'b1);
    tick();
    check1("raw_word_popped", cons.word_valid, 1'b0);

    // Mode toggle after five bits drops them
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    ctrl_mode = MODE_GATED;
    tick();
    ctrl_mode = MODE_RAW;
    tick();
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
    check1("toggle_no_early_word", cons.word_valid, 1'b0);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
    check1("toggle_word_valid", cons.word_valid, 1'b1);
    check8("toggle_word_data", cons.word_data, 8'h3C);
    tick();

    // Reset mid-word with two queued words
    cons.word_ready = 1'b0;
    send_word(8'h12);
    send_word(8'h34);
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    check1("pre_reset_valid", cons.word_valid, 1'b1);
    rst = 1'b1;
    ctrl_mode = MODE_GATED;
    tick();
    rst = 1'b0;
    check1("midreset_word_valid", cons.word_valid, 1'b0);
    check8("midreset_word_data", cons.word_data, 8'h00);
    check1("midreset_failure", failure, 1'b0);
    check1("midreset_overflow", overflow, 1'b0);
    cons.word_ready = 1'b1;
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    check1("post_reset_word_valid", cons.word_valid, 1'b1);
    check8("post_reset_word_data", cons.word_data, 8'hA5);
    check1("post_reset_failure", failure, 1'b0);
    tick();

    // APT window 16, cutoff 12: 11 matches pass, then a fresh window fails on its 12th match
    apt_w1 = '{1, 1, 1, 0, 1, 1, 1, 0, 1, 1, 0, 1, 1, 0, 1, 0};
    for (int i = 0; i < 16; i++) begin
      b_send(apt_w1[i]);
      if (i == 7) begin
        check1("apt_dut_word_valid", b_word_valid, 1'b1);
        check8("apt_dut_word_data", b_word_data, 8'h77);
      end
    end
    check1("apt_11_matches_no_fail", b_failure, 1'b0);
    b_send(1'b1);
    check1("apt_window_restart", b_failure, 1'b0);
    apt_w2 = '{1, 1, 0, 1, 1, 1, 0, 1, 1, 1, 0, 1, 1, 1};
    for (int i = 0; i < 14; i++) begin
      b_send(apt_w2[i]);
      if (i == 12) check1("apt_before_cutoff", b_failure, 1'b0);
    end
    check1("apt_fail_at_cutoff", b_failure, 1'b1);
    check1("apt_dut_no_overflow", b_overflow, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
